// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, one iteration per cycle.
// Define MULDIV_EARLY_OUT_EN to finish zero/special-case ops in one cycle.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [4:0]  rd_in,
    output logic        busy,
    output logic        done,
    output logic [4:0]  rd_addr,
    output logic [31:0] result,
    output logic        reg_write
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

`ifdef MULDIV_EARLY_OUT_EN
    localparam logic EARLY = 1'b1;
`else
    localparam logic EARLY = 1'b0;
`endif

    logic [1:0]  state;
    logic [2:0]  op;
    logic [4:0]  count;
    logic [31:0] opnd;
    logic [63:0] acc;
    logic        a_neg;
    logic        b_neg;
    logic        spec;
    logic [31:0] spec_val;

    logic        sa;
    logic        sb;
    logic        an;
    logic        bn;
    logic [31:0] am;
    logic [31:0] bm;
    logic        mzero;
    logic        div0;
    logic        ovf;
    logic        spec_c;
    logic [31:0] spec_v;
    logic        accept;

    assign accept = start && (state != S_CALC);

    // Operand conditioning at accept time
    always_comb begin
        sa = (funct3 == 3'b001) || (funct3 == 3'b010) ||
             (funct3 == 3'b100) || (funct3 == 3'b110);
        sb = (funct3 == 3'b001) || (funct3 == 3'b100) ||
             (funct3 == 3'b110);
        an = sa && rs1_data[31];
        bn = sb && rs2_data[31];
        am = an ? (~rs1_data + 32'd1) : rs1_data;
        bm = bn ? (~rs2_data + 32'd1) : rs2_data;
        mzero = !funct3[2] &&
                ((rs1_data == 32'd0) || (rs2_data == 32'd0));
        div0 = funct3[2] && (rs2_data == 32'd0);
        ovf = funct3[2] && !funct3[0] &&
              (rs1_data == 32'h8000_0000) &&
              (rs2_data == 32'hFFFF_FFFF);
        spec_c = mzero || div0 || ovf;
        spec_v = 32'd0;
        unique case (1'b1)
            div0:    spec_v = funct3[1] ? rs1_data : 32'hFFFF_FFFF;
            ovf:     spec_v = funct3[1] ? 32'd0 : 32'h8000_0000;
            default: spec_v = 32'd0;
        endcase
    end

    logic [32:0] msum;
    logic [63:0] mul_nxt;
    logic [32:0] dsh;
    logic        dge;
    logic [31:0] ddif;
    logic [63:0] div_nxt;
    logic [63:0] nxt;

    // Mul: shift-add, multiplier in acc low half.
    // Div: restoring, remainder in high half, quotient shifts in low.
    always_comb begin
        msum = {1'b0, acc[63:32]} +
               (acc[0] ? {1'b0, opnd} : 33'd0);
        mul_nxt = {msum, acc[31:1]};
        dsh = {acc[63:32], acc[31]};
        dge = dsh >= {1'b0, opnd};
        ddif = dsh[31:0] - opnd;
        div_nxt = {dge ? ddif : dsh[31:0], acc[30:0], dge};
        nxt = op[2] ? div_nxt : mul_nxt;
    end

    logic [63:0] prod;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] fin;

    always_comb begin
        prod = (a_neg ^ b_neg) ? (~nxt + 64'd1) : nxt;
        quo = (a_neg ^ b_neg) ? (~nxt[31:0] + 32'd1) : nxt[31:0];
        rem = a_neg ? (~nxt[63:32] + 32'd1) : nxt[63:32];
        if (spec)
            fin = spec_val;
        else if (!op[2])
            fin = (op[1:0] == 2'b00) ? prod[31:0] : prod[63:32];
        else if (op[1])
            fin = rem;
        else
            fin = quo;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            op       <= 3'd0;
            count    <= 5'd0;
            opnd     <= 32'd0;
            acc      <= 64'd0;
            a_neg    <= 1'b0;
            b_neg    <= 1'b0;
            spec     <= 1'b0;
            spec_val <= 32'd0;
            rd_addr  <= 5'd0;
            result   <= 32'd0;
        end else if (accept) begin
            op       <= funct3;
            rd_addr  <= rd_in;
            count    <= 5'd0;
            a_neg    <= an;
            b_neg    <= bn;
            spec     <= spec_c;
            spec_val <= spec_v;
            opnd     <= funct3[2] ? bm : am;
            acc      <= {32'd0, funct3[2] ? am : bm};
            if (EARLY && spec_c) begin
                state  <= S_DONE;
                result <= spec_v;
            end else begin
                state  <= S_CALC;
            end
        end else if (state == S_CALC) begin
            acc   <= nxt;
            count <= count + 5'd1;
            if (count == 5'd31) begin
                state  <= S_DONE;
                result <= fin;
            end
        end else if (state == S_DONE) begin
            state <= S_IDLE;
        end
    end

    assign busy      = (state == S_CALC);
    assign done      = (state == S_DONE);
    assign reg_write = done && (rd_addr != 5'd0);

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors for the RV32M multiply/divide unit.
// Expected values are hand-computed from the RV32M definitions.
module tb_muldiv_unit;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int FL = 1;
`else
    localparam int FL = 33;
`endif
    localparam int NL = 33;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rd_in;
    logic        busy;
    logic        done;
    logic [4:0]  rd_addr;
    logic [31:0] result;
    logic        reg_write;

    int nerr = 0;
    int nchk = 0;

    muldiv_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .funct3    (funct3),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .rd_in     (rd_in),
        .busy      (busy),
        .done      (done),
        .rd_addr   (rd_addr),
        .result    (result),
        .reg_write (reg_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_done(inout int lat);
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic do_op(input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         output int lat);
        @(negedge clk);
        start    = 1'b1;
        funct3   = f;
        rs1_data = a;
        rs2_data = b;
        rd_in    = rd;
        @(posedge clk);
        #1;
        start    = 1'b0;
        funct3   = ~f;
        rs1_data = 32'hDEAD_BEEF;
        rs2_data = 32'h1234_5678;
        rd_in    = ~rd;
        lat = 1;
        wait_done(lat);
    endtask

    task automatic op_chk(input string tag, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp,
                          input int elat);
        int lat;
        do_op(f, a, b, rd, lat);
        chk({tag, ".res"}, result, exp);
        chk({tag, ".lat"}, 32'(lat), 32'(elat));
        chk({tag, ".rd"}, 32'(rd_addr), 32'(rd));
        chk({tag, ".rw"}, 32'(reg_write), 32'(rd != 5'd0));
    endtask

    initial begin
        int lat;
        int dcnt;
        rst_n    = 1'b0;
        start    = 1'b0;
        funct3   = 3'd0;
        rs1_data = 32'd0;
        rs2_data = 32'd0;
        rd_in    = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.rw", 32'(reg_write), 32'd0);
        chk("rst.res", result, 32'd0);
        chk("rst.rd", 32'(rd_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        op_chk("mul", 3'b000, 32'h7, 32'hFFFF_FFFD, 5'd5,
               32'hFFFF_FFEB, NL);
        op_chk("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000,
               5'd6, 32'h4000_0000, NL);
        op_chk("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               5'd7, 32'hFFFF_FFFF, NL);
        op_chk("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               5'd8, 32'hFFFF_FFFE, NL);
        op_chk("div", 3'b100, 32'hFFFF_FFF9, 32'h2, 5'd9,
               32'hFFFF_FFFD, NL);
        op_chk("rem", 3'b110, 32'hFFFF_FFF9, 32'h2, 5'd10,
               32'hFFFF_FFFF, NL);
        op_chk("divu", 3'b101, 32'd100, 32'd7, 5'd11, 32'd14, NL);
        op_chk("remu", 3'b111, 32'd100, 32'd7, 5'd12, 32'd2, NL);
        op_chk("div0", 3'b100, 32'd5, 32'd0, 5'd13,
               32'hFFFF_FFFF, FL);
        op_chk("rem0", 3'b110, 32'd5, 32'd0, 5'd14, 32'd5, FL);
        op_chk("divu0", 3'b101, 32'hFFFF_FFF0, 32'd0, 5'd15,
               32'hFFFF_FFFF, FL);
        op_chk("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF,
               5'd16, 32'h8000_0000, FL);
        op_chk("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF,
               5'd17, 32'd0, FL);
        op_chk("mulz", 3'b001, 32'd0, 32'hFFFF_FFFF, 5'd18,
               32'd0, FL);
        op_chk("rd0", 3'b000, 32'd2, 32'd3, 5'd0, 32'd6, NL);

        // start re-pulsed while busy is ignored
        @(negedge clk);
        start = 1'b1; funct3 = 3'b000;
        rs1_data = 32'd3; rs2_data = 32'd4; rd_in = 5'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 1;
        repeat (5) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("ign.busy", 32'(busy), 32'd1);
        @(negedge clk);
        start = 1'b1; funct3 = 3'b100;
        rs1_data = 32'd100; rs2_data = 32'd7; rd_in = 5'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat++;
        wait_done(lat);
        chk("ign.res", result, 32'd12);
        chk("ign.rd", 32'(rd_addr), 32'd7);
        chk("ign.lat", 32'(lat), 32'(NL));

        // start held high through DONE: back-to-back accept
        @(negedge clk);
        start = 1'b1; funct3 = 3'b101;
        rs1_data = 32'd100; rs2_data = 32'd7; rd_in = 5'd3;
        @(posedge clk);
        #1;
        funct3 = 3'b111; rd_in = 5'd4;
        lat = 1;
        wait_done(lat);
        chk("b2b1.res", result, 32'd14);
        chk("b2b1.rd", 32'(rd_addr), 32'd3);
        chk("b2b1.lat", 32'(lat), 32'(NL));
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b2.busy", 32'(busy), 32'd1);
        lat = 1;
        wait_done(lat);
        chk("b2b2.res", result, 32'd2);
        chk("b2b2.rd", 32'(rd_addr), 32'd4);
        chk("b2b2.lat", 32'(lat), 32'(NL));

        // reset mid-operation aborts with no done pulse
        @(negedge clk);
        start = 1'b1; funct3 = 3'b001;
        rs1_data = 32'h8000_0000; rs2_data = 32'h8000_0000;
        rd_in = 5'd20;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.done", 32'(done), 32'd0);
        chk("abort.res", result, 32'd0);
        dcnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        rst_n = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) dcnt++;
        end
        chk("abort.nodone", 32'(dcnt), 32'd0);
        chk("abort.res2", result, 32'd0);
        op_chk("postrst", 3'b011, 32'hFFFF_FFFF, 32'd2, 5'd21,
               32'd1, NL);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide execution unit. It sits directly downstream of the register file: it consumes the rs1/rs2 read data plus the destination address from decode, computes over multiple cycles, and returns a result, destination address and write-enable that drive the register file write port. A start/busy/done handshake lets the pipeline stall while an operation is in flight.

## Interface

Parameters:
- none. Datapath is fixed at 32 bits and the iteration count at 32.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; accepted only when busy=0
- funct3  in  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1_data  in  32  operand A, dividend/multiplicand
- rs2_data  in  32  operand B, divisor/multiplier
- rd_in  in  5  destination register
- busy  out  1  high while state=CALC
- done  out  1  one-cycle pulse; result valid
- rd_addr  out  5  latched destination, to register file
- result  out  32  to register file write_data
- reg_write  out  1  done && rd_addr!=0, to register file RegWrite

## Operation

- States: IDLE, CALC, DONE.
  - IDLE: start=1 latches funct3, rd_in, operand magnitudes and sign flags, and clears count and the accumulator. Next state is CALC, or DONE on the fast path.
  - CALC: performs one iteration per cycle with a 5-bit count 0..31. After the iteration at count=31, next state is DONE.
  - DONE: done=1; then IDLE unconditionally.
- busy=0 in IDLE and DONE, so start may be accepted in DONE. It is then latched exactly as in IDLE, giving back-to-back operations with no gap.
- start while busy=1 is ignored; operands are not re-sampled.
- Multiply:
  - Shift-add on magnitudes into a 64-bit product.
  - Signedness: MULH treats both operands as signed, MULHSU A signed and B unsigned, MULHU and MUL both unsigned.
  - The final product is negated if the sign flags differ.
  - MUL returns product[31:0]; the others return product[63:32].
- Divide:
  - Restoring shift-subtract on magnitudes; 32-bit quotient and 32-bit remainder.
  - DIV/REM are signed. The quotient is negated if the operand signs differ; the remainder takes the dividend's sign.
- Special cases, following the RISC-V spec, always:
  - Divide by zero: quotient = 0xFFFFFFFF, remainder = dividend.
  - DIV/REM with 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- result and rd_addr are registered and hold their value until the next accepted start. reg_write is high only in the DONE cycle.
- Reset values: state=IDLE, busy=0, done=0, reg_write=0, result=0, rd_addr=0.
- Reset asserted mid-operation aborts immediately. No done pulse is produced for the aborted op.

## Timing

- start sampled high at edge k, normal path:
  - CALC iterations run at edges k+1..k+32.
  - done, result and reg_write are valid in the cycle after edge k+32, i.e. 33 cycles after the accept edge.
  - busy is high between edges k and k+32.
- Fast path (only with the macro): DONE is entered at edge k, and done is valid in the cycle after edge k.
- Operands only need to be stable in the cycle in which start is sampled.
- result updates at the same edge at which done rises.

## Configuration

- MULDIV_EARLY_OUT_EN defined:
  - Divide-by-zero, signed overflow, and multiply with either operand 0 take the fast path: 1-cycle latency, busy never rises.
- Undefined:
  - Every operation takes the full 32-iteration path.
  - Results are bit-identical; only latency differs.

## Test plan

- MUL 7 × -3 (0x00000007, 0xFFFFFFFD), rd=5 -> after 33 cycles done=1, result=0xFFFFFFEB, rd_addr=5, reg_write=1.
- MULH 0x80000000 × 0x80000000 -> result=0x40000000. MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> result=0xFFFFFFFF. MULHU same operands -> result=0xFFFFFFFE.
- DIV -7/2 -> result=0xFFFFFFFD. REM -7/2 -> result=0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIV 5/0 -> 0xFFFFFFFF. REM 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. Latency is 1 cycle with MULDIV_EARLY_OUT_EN, 33 cycles without.
- start re-pulsed with different operands while busy -> ignored, first result returned. start held high through DONE -> second op accepted back-to-back. rd=0 -> done=1, reg_write=0.
- rst_n pulsed low at iteration 10 -> busy=0, done never pulses, result=0. A subsequent MULHU 0xFFFFFFFF × 2 -> result=0x00000001.
